// File: rtl/seg7_hex_sequencer_if.sv
// Display-value handshake and peripheral write bus for the 7-segment sequencer.
// Handshake: a value transfers on a cycle where in_valid and in_ready are both high.
interface seg7_hex_sequencer_if;
  logic        in_valid;
  logic [15:0] in_data;
  logic [3:0]  in_dp;
  logic        in_ready;
  logic        blank_lz;
  logic        blink_en;
  logic [7:0]  per_addr;
  logic [15:0] per_din;
  logic        per_en;
  logic [1:0]  per_wen;
  logic        busy;
  logic        done;
  logic [1:0]  state_dbg;

  modport master (
    output in_valid, in_data, in_dp, blank_lz, blink_en,
    input  in_ready, per_addr, per_din, per_en, per_wen, busy, done, state_dbg
  );

  modport slave (
    input  in_valid, in_data, in_dp, blank_lz, blink_en,
    output in_ready, per_addr, per_din, per_en, per_wen, busy, done, state_dbg
  );
endinterface

// File: rtl/seg7_hex_sequencer.sv
// Converts a 16-bit hex value into four 7-segment bytes and writes them to a
// display peripheral as two 16-bit words, with optional blanking and blinking.
module seg7_hex_sequencer #(
  parameter logic [8:0] BASE_ADDR = 9'h090,
  parameter int         BLINK_W   = 24
) (
  input logic               mclk,
  input logic               puc,
  seg7_hex_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR0  = 2'd1,
    WR1  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [7:0] ADDR0 = BASE_ADDR[8:1];
  localparam logic [7:0] ADDR1 = BASE_ADDR[8:1] + 8'd1;

  function automatic logic [7:0] hex_seg(input logic [3:0] n);
    logic [7:0] s;
    case (n)
      4'h0: s = 8'hFC;
      4'h1: s = 8'h60;
      4'h2: s = 8'hDA;
      4'h3: s = 8'hF2;
      4'h4: s = 8'h66;
      4'h5: s = 8'hB6;
      4'h6: s = 8'hBE;
      4'h7: s = 8'hE0;
      4'h8: s = 8'hFE;
      4'h9: s = 8'hF6;
      4'hA: s = 8'hEE;
      4'hB: s = 8'h3E;
      4'hC: s = 8'h9C;
      4'hD: s = 8'h7A;
      4'hE: s = 8'h9E;
      default: s = 8'h8E;
    endcase
    return s;
  endfunction

  // Blanking only removes segments; the decimal point is ORed in afterwards.
  function automatic logic [31:0] encode(input logic [15:0] d, input logic [3:0] dp,
                                         input logic blank);
    logic [3:0]  bl;
    logic [31:0] r;
    bl[3] = blank & (d[15:12] == 4'h0);
    bl[2] = bl[3] & (d[11:8] == 4'h0);
    bl[1] = bl[2] & (d[7:4] == 4'h0);
    bl[0] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      r[8*k +: 8] = (bl[k] ? 8'h00 : hex_seg(d[4*k +: 4])) | {7'b0, dp[k]};
    end
    return r;
  endfunction

  state_t               state;
  logic [15:0]          cap_data;
  logic [3:0]           cap_dp;
  logic                 cap_blank;
  logic                 loaded;
  logic                 phase;
  logic                 pending;
  logic [BLINK_W-1:0]   cnt;
  logic [7:0]           per_addr_q;
  logic [15:0]          per_din_q;
  logic                 per_en_q;
  logic [1:0]           per_wen_q;
  logic                 done_q;

  logic [31:0] pat_new;
  logic [31:0] pat_cur;
  logic        tick;
  logic        accept;

  assign pat_new = encode(bus.in_data, bus.in_dp, bus.blank_lz);
  assign pat_cur = encode(cap_data, cap_dp, cap_blank);
  assign tick    = (cnt == {BLINK_W{1'b1}});
  assign accept  = bus.in_valid & (state == IDLE);

  assign bus.in_ready  = (state == IDLE);
  assign bus.busy      = (state != IDLE);
  assign bus.state_dbg = state;
  assign bus.per_addr  = per_addr_q;
  assign bus.per_din   = per_din_q;
  assign bus.per_en    = per_en_q;
  assign bus.per_wen   = per_wen_q;
  assign bus.done      = done_q;

  always_ff @(posedge mclk) begin
    if (puc) begin
      state      <= IDLE;
      cap_data   <= 16'h0;
      cap_dp     <= 4'h0;
      cap_blank  <= 1'b0;
      loaded     <= 1'b0;
      phase      <= 1'b1;
      pending    <= 1'b0;
      cnt        <= '0;
      per_addr_q <= 8'h0;
      per_din_q  <= 16'h0;
      per_en_q   <= 1'b0;
      per_wen_q  <= 2'b00;
      done_q     <= 1'b0;
    end else begin
      cnt        <= cnt + {{(BLINK_W-1){1'b0}}, 1'b1};
      per_addr_q <= 8'h0;
      per_din_q  <= 16'h0;
      per_en_q   <= 1'b0;
      per_wen_q  <= 2'b00;
      done_q     <= 1'b0;

      if (!bus.blink_en) begin
        phase   <= 1'b1;
        pending <= 1'b0;
      end else if (tick && loaded && state != IDLE) begin
        pending <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (accept) begin
            cap_data   <= bus.in_data;
            cap_dp     <= bus.in_dp;
            cap_blank  <= bus.blank_lz;
            loaded     <= 1'b1;
            phase      <= 1'b1;
            pending    <= 1'b0;
            state      <= WR0;
            per_en_q   <= 1'b1;
            per_wen_q  <= 2'b11;
            per_addr_q <= ADDR0;
            per_din_q  <= pat_new[15:0];
          end else if (bus.blink_en && loaded && (tick || pending)) begin
            // Currently on means the new phase is off, so write blanks.
            phase      <= ~phase;
            pending    <= 1'b0;
            state      <= WR0;
            per_en_q   <= 1'b1;
            per_wen_q  <= 2'b11;
            per_addr_q <= ADDR0;
            per_din_q  <= phase ? 16'h0000 : pat_cur[15:0];
          end
        end
        WR0: begin
          state      <= WR1;
          per_en_q   <= 1'b1;
          per_wen_q  <= 2'b11;
          per_addr_q <= ADDR1;
          per_din_q  <= phase ? pat_cur[31:16] : 16'h0000;
        end
        WR1: begin
          state  <= DONE;
          done_q <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
